// File: rtl/xm_mem_pkg.sv
// Shared constants, read-port state encoding and byte-merge helper for xm_main_memory.
package xm_mem_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DONE
    } rd_port_state_t;

    // Enabled byte lanes come from new_word, the rest keep old_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xm_mem_rd_port.sv
// One read port: request FSM, latency counter and completion data register.
module xm_mem_rd_port
    import xm_mem_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] word,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    rd_port_state_t    state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word_q;

    // Data is captured at acceptance so later writes never leak into this read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RD_IDLE;
            cnt     <= '0;
            word_q  <= '0;
            rd_done <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (rd_en) begin
                        word_q <= word;
                        cnt    <= CNT_W'(RD_LATENCY - 1);
                        if (RD_LATENCY == 1) begin
                            state   <= RD_DONE;
                            rd_done <= 1'b1;
                            rd_data <= word;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= RD_DONE;
                        rd_done <= 1'b1;
                        rd_data <= word_q;
                    end
                end
                RD_DONE: begin
                    state <= RD_IDLE;
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/xm_main_memory.sv
// xmakina main memory: 16-bit word array, two latency-configurable read ports, one byte-enabled write port.
// Optional XM_MEM_WR_FORWARD_EN: same-edge write to the same address is forwarded into a newly accepted read.
module xm_main_memory
    import xm_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 32768,
    parameter int unsigned RD_LATENCY = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en   [0:1],
    input  logic [ADDR_W-1:0] rd_addr [0:1],
    input  logic [BE_W-1:0]   wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_done [0:1],
    output logic [DATA_W-1:0] rd_data [0:1]
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;

    assign wr_ok  = (32'(wr_addr) < MEM_DEPTH);
    assign wr_idx = IDX_W'(wr_addr);

    // Out-of-range writes are dropped rather than aliased onto a valid word.
    always_ff @(posedge clk) begin
        if (!reset && (wr_en != '0) && wr_ok) begin
            mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_en);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              rd_ok;
        logic [IDX_W-1:0]  rd_idx;
        logic [DATA_W-1:0] arr_word;
        logic [DATA_W-1:0] word;

        assign rd_ok    = (32'(rd_addr[p]) < MEM_DEPTH);
        assign rd_idx   = IDX_W'(rd_addr[p]);
        assign arr_word = mem[rd_idx];

`ifdef XM_MEM_WR_FORWARD_EN
        assign word = !rd_ok ? '0 :
                      ((wr_en != '0) && (wr_addr == rd_addr[p])) ? merge_bytes(arr_word, wr_data, wr_en) :
                      arr_word;
`else
        assign word = rd_ok ? arr_word : '0;
`endif

        xm_mem_rd_port #(
            .RD_LATENCY (RD_LATENCY)
        ) u_rd_port (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (rd_en[p]),
            .word    (word),
            .rd_done (rd_done[p]),
            .rd_data (rd_data[p])
        );
    end

endmodule

// File: tb/tb_xm_main_memory.sv
// Directed bench for xm_main_memory: three instances (latency 4, latency 3, 1K-deep latency 1) share inputs.
module tb_xm_main_memory;
    import xm_mem_pkg::*;

    logic              clk;
    logic              reset;
    logic              rd_en   [0:1];
    logic [ADDR_W-1:0] rd_addr [0:1];
    logic [BE_W-1:0]   wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              done_l4 [0:1];
    logic [DATA_W-1:0] data_l4 [0:1];
    logic              done_l3 [0:1];
    logic [DATA_W-1:0] data_l3 [0:1];
    logic              done_dk [0:1];
    logic [DATA_W-1:0] data_dk [0:1];

    int total = 0;
    int bad   = 0;

    xm_main_memory #(.MEM_DEPTH(32768), .RD_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_done(done_l4), .rd_data(data_l4));

    xm_main_memory #(.MEM_DEPTH(32768), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_done(done_l3), .rd_data(data_l3));

    xm_main_memory #(.MEM_DEPTH(1024), .RD_LATENCY(1)) u_dk (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_done(done_dk), .rd_data(data_dk));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int d, input int p);
        case (d)
            0:       return done_l4[p];
            1:       return done_l3[p];
            default: return done_dk[p];
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] get_data(input int d, input int p);
        case (d)
            0:       return data_l4[p];
            1:       return data_l3[p];
            default: return data_dk[p];
        endcase
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        wr_addr = a;
        wr_data = d;
        wr_en   = be;
        tick();
        wr_en   = '0;
    endtask

    // Holds rd_en until the chosen instance completes; returns data and cycles from request to rd_done.
    task automatic do_read(input int d, input int p, input logic [ADDR_W-1:0] a, input string tag,
                           output logic [DATA_W-1:0] q, output int lat);
        bit seen;
        seen = 1'b0;
        q    = 'x;
        lat  = 0;
        rd_en[p]   = 1'b1;
        rd_addr[p] = a;
        for (int i = 1; i <= 32 && !seen; i++) begin
            tick();
            if (get_done(d, p)) begin
                seen = 1'b1;
                q    = get_data(d, p);
                lat  = i;
            end
        end
        rd_en[p] = 1'b0;
        tick();
        chk(tag, 32'(seen), 32'd1);
    endtask

    logic [DATA_W-1:0] q;
    int                lat;
    int                pulses;
    bit                seen;

    initial begin
        reset      = 1'b0;
        rd_en[0]   = 1'b0;
        rd_en[1]   = 1'b0;
        rd_addr[0] = '0;
        rd_addr[1] = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_done_l4_0", 32'(done_l4[0]), 32'd0);
        chk("rst_done_l4_1", 32'(done_l4[1]), 32'd0);
        chk("rst_data_l3_1", 32'(data_l3[1]), 32'h0);
        chk("rst_data_dk_0", 32'(data_dk[0]), 32'h0);

        // Latency 4 read, then a read aborted by reset on cycle 2
        do_write(15'h0010, 16'hC0DE, 2'b11);
        do_read(0, 0, 15'h0010, "l4_rd1_done", q, lat);
        chk("l4_rd1_data", 32'(q), 32'hC0DE);
        chk("l4_rd1_lat", 32'(lat), 32'd4);
        rd_en[0]   = 1'b1;
        rd_addr[0] = 15'h0010;
        tick();
        tick();
        reset    = 1'b1;
        rd_en[0] = 1'b0;
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_l4[0]) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        chk("abort_data_zero", 32'(data_l4[0]), 32'h0);
        do_read(0, 0, 15'h0010, "abort_reread_done", q, lat);
        chk("abort_word_kept", 32'(q), 32'hC0DE);

        // Byte-lane writes
        do_reset();
        do_write(15'h0005, 16'hAAAA, 2'b11);
        do_write(15'h0005, 16'h1234, 2'b01);
        do_read(2, 0, 15'h0005, "be_lo_done", q, lat);
        chk("be_lo_data", 32'(q), 32'hAA34);
        chk("be_lo_lat", 32'(lat), 32'd1);
        do_write(15'h0005, 16'h5600, 2'b10);
        do_read(2, 1, 15'h0005, "be_hi_done", q, lat);
        chk("be_hi_data", 32'(q), 32'h5634);

        // Held rd_en on latency-3 port 1: rd_done only in cycles 3 and 7
        do_write(15'h0100, 16'h1357, 2'b11);
        do_reset();
        rd_en[1]   = 1'b1;
        rd_addr[1] = 15'h0100;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("b2b_done_c%0d", k), 32'(done_l3[1]), ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
            if (k == 3) chk("b2b_data", 32'(data_l3[1]), 32'h1357);
        end
        rd_en[1] = 1'b0;

        // Both ports on the same address in the same cycle
        do_reset();
        do_write(15'h0200, 16'hBEEF, 2'b11);
        rd_en[0]   = 1'b1;
        rd_en[1]   = 1'b1;
        rd_addr[0] = 15'h0200;
        rd_addr[1] = 15'h0200;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (done_dk[0] || done_dk[1]) begin
                seen = 1'b1;
                chk("dual_done0", 32'(done_dk[0]), 32'd1);
                chk("dual_done1", 32'(done_dk[1]), 32'd1);
                chk("dual_data0", 32'(data_dk[0]), 32'hBEEF);
                chk("dual_data1", 32'(data_dk[1]), 32'hBEEF);
            end
        end
        rd_en[0] = 1'b0;
        rd_en[1] = 1'b0;
        tick();
        chk("dual_seen", 32'(seen), 32'd1);

        // Same-edge write and read accept on one address
        do_reset();
        do_write(15'h0300, 16'h1111, 2'b11);
        wr_addr    = 15'h0300;
        wr_data    = 16'h2222;
        wr_en      = 2'b11;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 15'h0300;
        tick();
        wr_en = '0;
        seen  = 1'b0;
        q     = 'x;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (done_dk[0]) begin
                seen = 1'b1;
                q    = data_dk[0];
            end else begin
                tick();
            end
        end
        rd_en[0] = 1'b0;
        tick();
        chk("raw_seen", 32'(seen), 32'd1);
`ifdef XM_MEM_WR_FORWARD_EN
        chk("raw_data", 32'(q), 32'h2222);
`else
        chk("raw_data", 32'(q), 32'h1111);
`endif
        do_read(2, 0, 15'h0300, "raw_after_done", q, lat);
        chk("raw_after_data", 32'(q), 32'h2222);

        // Out-of-range on the 1K-deep instance
        do_reset();
        do_write(15'h0000, 16'h0F0F, 2'b11);
        do_read(2, 0, 15'h0000, "oor_pre_done", q, lat);
        chk("oor_pre_data", 32'(q), 32'h0F0F);
        do_write(15'h0400, 16'hDEAD, 2'b11);
        do_read(2, 0, 15'h0400, "oor_rd_done", q, lat);
        chk("oor_rd_data", 32'(q), 32'h0000);
        do_read(2, 1, 15'h0000, "oor_alias_done", q, lat);
        chk("oor_alias_data", 32'(q), 32'h0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
